// File: rtl/sd_sector_arbiter.sv
// Round-robin sector arbiter between a reader and a writer sharing one SD controller.
// Turns the controller's level byte strobes into one-cycle per-byte handshakes, with a stall watchdog.
module sd_sector_arbiter #(
   parameter int SECTOR_BYTES   = 512,
   parameter int TIMEOUT_CYCLES = 2500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_req,
   input  logic [22:0] rd_sector,
   output logic        rd_ack,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        rd_done,
   input  logic        wr_req,
   input  logic [22:0] wr_sector,
   output logic        wr_ack,
   input  logic [7:0]  wr_data,
   output logic        wr_data_req,
   output logic        wr_done,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic [31:0] sd_address,
   output logic [7:0]  sd_din,
   input  logic [7:0]  sd_dout,
   input  logic        sd_byte_available,
   input  logic        sd_ready_for_next_byte,
   input  logic        sd_ready,
   output logic        err,
   output logic [2:0]  state
);

   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      XFER  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_t;

   state_t         cur;
   state_t         nxt;
   logic           dir_q;
   logic           last_grant_q;
   logic [22:0]    sector_q;
   logic [9:0]     count_q;
   logic [WDW-1:0] wd_q;
   logic           avail_prev;
   logic           rnb_prev;
   logic           grant;
   logic           grant_wr;
   logic           edge_hit;
   logic           cnt_last;
   logic           wd_expired;

   always_comb begin
      grant      = sd_ready & (rd_req | wr_req);
      // on a tie, write wins only if read was served last
      grant_wr   = wr_req & (~rd_req | ~last_grant_q);
      edge_hit   = 1'b0;
      if (cur == XFER) begin
         if (dir_q) edge_hit = sd_ready_for_next_byte & ~rnb_prev;
         else       edge_hit = sd_byte_available & ~avail_prev;
      end
      cnt_last   = (count_q == 10'(SECTOR_BYTES - 1));
      wd_expired = (wd_q == WDW'(TIMEOUT_CYCLES - 1));
   end

   always_comb begin
      nxt = cur;
      unique case (cur)
         IDLE:  if (grant) nxt = ISSUE;
         ISSUE: nxt = XFER;
         XFER: begin
            if (edge_hit && cnt_last) nxt = DRAIN;
            else if (!edge_hit && wd_expired) nxt = ERROR;
         end
         DRAIN: begin
            if (sd_ready) nxt = DONE;
            else if (wd_expired) nxt = ERROR;
         end
         DONE:  nxt = IDLE;
         ERROR: nxt = ERROR;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur          <= IDLE;
         dir_q        <= 1'b0;
         last_grant_q <= 1'b1;
         sector_q     <= '0;
         count_q      <= '0;
         wd_q         <= '0;
         avail_prev   <= 1'b0;
         rnb_prev     <= 1'b0;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         sd_din       <= '0;
         wr_data_req  <= 1'b0;
      end else begin
         cur         <= nxt;
         avail_prev  <= sd_byte_available;
         rnb_prev    <= sd_ready_for_next_byte;
         rd_valid    <= 1'b0;
         wr_data_req <= 1'b0;
         if (cur == IDLE && grant) begin
            dir_q    <= grant_wr;
            sector_q <= grant_wr ? wr_sector : rd_sector;
         end
         if (edge_hit) begin
            count_q <= count_q + 10'd1;
            if (dir_q) begin
               sd_din      <= wr_data;
               wr_data_req <= 1'b1;
            end else begin
               rd_data  <= sd_dout;
               rd_valid <= 1'b1;
            end
         end
         if (cur == DONE) begin
            count_q      <= '0;
            last_grant_q <= dir_q;
         end
         // watchdog measures idle time since the last byte or state change
         if (edge_hit || nxt != cur) wd_q <= '0;
         else if (cur == XFER || cur == DRAIN) wd_q <= wd_q + 1'b1;
      end
   end

   assign sd_rd      = (cur == ISSUE) & ~dir_q;
   assign sd_wr      = (cur == ISSUE) & dir_q;
   assign rd_ack     = sd_rd;
   assign wr_ack     = sd_wr;
   assign rd_done    = (cur == DONE) & ~dir_q;
   assign wr_done    = (cur == DONE) & dir_q;
   assign err        = (cur == ERROR);
   assign state      = cur;
   assign sd_address = {sector_q, 9'b0};

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter with a small SD controller model.
// Expected bytes are queued at stimulus time and popped as the DUT hands them over.
module tb_sd_sector_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd_req = 1'b0;
   logic [22:0] rd_sector = '0;
   logic        rd_ack;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_done;
   logic        wr_req = 1'b0;
   logic [22:0] wr_sector = '0;
   logic        wr_ack;
   logic [7:0]  wr_data = '0;
   logic        wr_data_req;
   logic        wr_done;
   logic        sd_rd;
   logic        sd_wr;
   logic [31:0] sd_address;
   logic [7:0]  sd_din;
   logic [7:0]  sd_dout = '0;
   logic        sd_byte_available = 1'b0;
   logic        sd_ready_for_next_byte = 1'b0;
   logic        sd_ready = 1'b1;
   logic        err;
   logic [2:0]  state;

   int n_vec = 0;
   int n_err = 0;
   int c_rd_valid = 0, c_wr_dreq = 0, c_rd_ack = 0, c_wr_ack = 0;
   int c_sd_rd = 0, c_sd_wr = 0, c_rd_done = 0, c_wr_done = 0;
   logic [7:0] rdq[$];
   logic [7:0] wrq[$];
   bit         grant_log[$];

   sd_sector_arbiter #(.SECTOR_BYTES(512), .TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_sector(rd_sector), .rd_ack(rd_ack),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
      .wr_req(wr_req), .wr_sector(wr_sector), .wr_ack(wr_ack),
      .wr_data(wr_data), .wr_data_req(wr_data_req), .wr_done(wr_done),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_address(sd_address),
      .sd_din(sd_din), .sd_dout(sd_dout),
      .sd_byte_available(sd_byte_available),
      .sd_ready_for_next_byte(sd_ready_for_next_byte),
      .sd_ready(sd_ready), .err(err), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({rd_ack, rd_data, rd_valid, rd_done, wr_ack, wr_data_req,
                  wr_done, sd_rd, sd_wr, sd_address, sd_din, err, state});
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (rd_valid) begin
            c_rd_valid++;
            if (rdq.size() == 0) check("rd_spurious", 1, 0);
            else check("rd_data", rd_data, rdq.pop_front());
         end
         if (wr_data_req) begin
            c_wr_dreq++;
            if (wrq.size() == 0) check("wr_spurious", 1, 0);
            else check("sd_din", sd_din, wrq.pop_front());
         end
         if (rd_ack) c_rd_ack++;
         if (wr_ack) c_wr_ack++;
         if (sd_rd) c_sd_rd++;
         if (sd_wr) c_sd_wr++;
         if (rd_done) c_rd_done++;
         if (wr_done) c_wr_done++;
         if (rd_ack || wr_ack) grant_log.push_back(wr_ack);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rd_req = 1'b0;
      wr_req = 1'b0;
      sd_byte_available = 1'b0;
      sd_ready_for_next_byte = 1'b0;
      sd_ready = 1'b1;
      rdq.delete();
      wrq.delete();
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", outs(), 0);
      reset = 1'b0;
      tick();
   endtask

   task automatic wait_ack(output bit ok, output bit is_wr, output int lat);
      ok = 0;
      is_wr = 0;
      lat = 0;
      for (int t = 0; t < 200; t++) begin
         tick();
         if (rd_ack || wr_ack) begin
            ok = 1;
            is_wr = wr_ack;
            lat = t + 1;
            break;
         end
      end
      check("ack_seen", 64'(ok), 1);
   endtask

   task automatic serve_read(input logic [31:0] exp_addr, input int nbytes,
                             input bit finish);
      check("rd_addr", sd_address, exp_addr);
      check("sd_rd_hi", sd_rd, 1);
      rd_req = 1'b0;
      sd_ready = 1'b0;
      tick();
      check("sd_rd_1cyc", sd_rd, 0);
      for (int i = 0; i < nbytes; i++) begin
         sd_dout = 8'(i);
         rdq.push_back(8'(i));
         sd_byte_available = 1'b1;
         tick();
         if (i == 0) check("rd_lat", rd_valid, 1);
         tick();
         sd_byte_available = 1'b0;
         repeat (2) tick();
      end
      if (finish) begin
         repeat (2) tick();
         check("rd_drain", state, 3);
         sd_ready = 1'b1;
         tick();
         check("rd_done", rd_done, 1);
         tick();
         check("rd_done_1cyc", rd_done, 0);
         check("idle_after_rd", state, 0);
      end
   endtask

   task automatic serve_write(input logic [31:0] exp_addr, input int nbytes,
                              input bit finish);
      check("wr_addr", sd_address, exp_addr);
      check("sd_wr_hi", sd_wr, 1);
      wr_req = 1'b0;
      sd_ready = 1'b0;
      tick();
      check("sd_wr_1cyc", sd_wr, 0);
      for (int i = 0; i < nbytes; i++) begin
         sd_ready_for_next_byte = 1'b1;
         tick();
         if (i == 0) check("wr_lat", wr_data_req, 1);
         if (wr_data_req) begin
            wr_data = wr_data + 8'd1;
            wrq.push_back(wr_data);
         end
         tick();
         sd_ready_for_next_byte = 1'b0;
         repeat (2) tick();
      end
      if (finish) begin
         repeat (2) tick();
         sd_ready = 1'b1;
         tick();
         check("wr_done", wr_done, 1);
         tick();
         check("wr_done_1cyc", wr_done, 0);
      end
   endtask

   task automatic arm_writer(input logic [22:0] sec);
      wr_sector = sec;
      wr_data = 8'd0;
      wrq.delete();
      wrq.push_back(8'd0);
      wr_req = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end

   initial begin
      bit ok, is_wr;
      int lat, b_v, b_a, b_c, b_d, b_e;

      do_reset();

      // single read of sector 5
      b_v = c_rd_valid; b_a = c_rd_ack; b_c = c_sd_rd; b_d = c_rd_done;
      rd_sector = 23'd5;
      rd_req = 1'b1;
      wait_ack(ok, is_wr, lat);
      check("rd_cmd_lat", 64'(lat), 1);
      check("rd_dir", 64'(is_wr), 0);
      serve_read(32'h0000_0A00, 512, 1);
      check("rd_count", 64'(c_rd_valid - b_v), 512);
      check("rd_acks", 64'(c_rd_ack - b_a), 1);
      check("sd_rd_pulses", 64'(c_sd_rd - b_c), 1);
      check("rd_dones", 64'(c_rd_done - b_d), 1);
      check("rdq_empty", 64'(rdq.size()), 0);

      // single write of sector 3
      b_v = c_wr_dreq; b_a = c_wr_ack; b_c = c_sd_wr; b_d = c_wr_done;
      arm_writer(23'd3);
      wait_ack(ok, is_wr, lat);
      check("wr_dir", 64'(is_wr), 1);
      serve_write(32'h0000_0600, 512, 1);
      check("wr_count", 64'(c_wr_dreq - b_v), 512);
      check("wr_acks", 64'(c_wr_ack - b_a), 1);
      check("sd_wr_pulses", 64'(c_sd_wr - b_c), 1);
      check("wr_dones", 64'(c_wr_done - b_d), 1);

      // tie after reset, both kept pending: read, write, read, write
      do_reset();
      grant_log.delete();
      rd_sector = 23'd10;
      rd_req = 1'b1;
      arm_writer(23'd20);
      for (int k = 0; k < 4; k++) begin
         wait_ack(ok, is_wr, lat);
         if (!ok) break;
         if (is_wr) begin
            serve_write(32'h0000_2800, 512, 1);
            arm_writer(23'd20);
         end else begin
            serve_read(32'h0000_1400, 512, 1);
            rd_req = 1'b1;
         end
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
      tick();
      check("tie_grants", 64'(grant_log.size()), 4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++)
         check($sformatf("tie_order%0d", k), 64'(grant_log[k]), 64'(k % 2));
      repeat (3) tick();

      // request held off while the card is busy
      wrq.delete();
      b_a = c_rd_ack; b_c = c_sd_rd;
      sd_ready = 1'b0;
      rd_sector = 23'd2;
      rd_req = 1'b1;
      repeat (10) tick();
      check("busy_no_ack", 64'(c_rd_ack - b_a), 0);
      check("busy_no_sd_rd", 64'(c_sd_rd - b_c), 0);
      sd_ready = 1'b1;
      tick();
      check("ack_after_ready", rd_ack, 1);
      serve_read(32'h0000_0400, 512, 1);

      // stalled card trips the watchdog
      b_d = c_rd_done; b_e = c_wr_ack;
      rd_sector = 23'd7;
      rd_req = 1'b1;
      wait_ack(ok, is_wr, lat);
      serve_read(32'h0000_0E00, 100, 0);
      repeat (996) tick();
      check("wd_not_yet_err", err, 0);
      check("wd_not_yet_state", state, 2);
      tick();
      check("wd_err", err, 1);
      check("wd_state", state, 5);
      check("wd_no_sd_rd", sd_rd, 0);
      sd_ready = 1'b1;
      wr_sector = 23'd4;
      wr_req = 1'b1;
      repeat (20) tick();
      check("err_no_ack", 64'(c_wr_ack - b_e), 0);
      check("err_no_done", 64'(c_rd_done - b_d), 0);
      check("err_sticky", state, 5);
      do_reset();
      check("err_cleared", err, 0);

      // reset in the middle of a write, then a clean read
      arm_writer(23'd9);
      wait_ack(ok, is_wr, lat);
      serve_write(32'h0000_1200, 200, 0);
      check("mid_write_din", sd_din, 8'd199);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_outs", outs(), 0);
      do_reset();
      b_v = c_rd_valid; b_d = c_rd_done; b_e = c_wr_done;
      rd_sector = 23'd1;
      rd_req = 1'b1;
      wait_ack(ok, is_wr, lat);
      check("post_rst_dir", 64'(is_wr), 0);
      serve_read(32'h0000_0200, 512, 1);
      check("post_rst_bytes", 64'(c_rd_valid - b_v), 512);
      check("post_rst_done", 64'(c_rd_done - b_d), 1);
      check("no_wr_done", 64'(c_wr_done - b_e), 0);

      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
